// File: rtl/gate_exerciser_pkg.sv
// Shared constants, state encoding and the golden gate function for the
// gate-microtile exerciser and any future checker of the same gate block.
package gate_exerciser_pkg;

   localparam int VEC_COUNT = 16;
   localparam int VEC_W     = $clog2(VEC_COUNT);
   localparam int SETTLE_W  = 4;
   localparam int RESP_W    = 3;

   localparam int UI_START      = 0;
   localparam int UI_CONT       = 1;
   localparam int UI_SETTLE_LSB = 4;
   localparam int UIO_RESP_LSB  = 4;

   localparam int UO_BUSY    = 0;
   localparam int UO_PASS    = 1;
   localparam int UO_FAIL    = 2;
   localparam int UO_DONE    = 3;
   localparam int UO_IDX_LSB = 4;

   localparam logic [7:0] OE_DRIVE = 8'h0F;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   // Expected gate response for stimulus {d,c,b,a}: {~d, ~c, a&b}.
   function automatic logic [RESP_W-1:0] golden(input logic [VEC_W-1:0] vec);
      return {~vec[3], ~vec[2], vec[1] & vec[0]};
   endfunction

endpackage

// File: rtl/gate_exerciser_check.sv
// Combinational response checker: flags any difference between the gate
// response and the golden value for the applied vector.
module gate_exerciser_check
   import gate_exerciser_pkg::*;
(
   input  logic [VEC_W-1:0]  i_vec,
   input  logic [RESP_W-1:0] i_resp,
   output logic              o_mismatch
);

   assign o_mismatch = (i_resp != golden(i_vec));

endmodule

// File: rtl/tt_um_gate_exerciser.sv
// Initiator-side exerciser: sweeps all 16 vectors into a 4-input gate block,
// waits N settle cycles per vector, and records pass/fail plus first bad vector.
module tt_um_gate_exerciser
   import gate_exerciser_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [7:0] uo_out
);

   state_t              r_state;
   state_t              w_state_next;
   logic                r_start_d;
   logic [VEC_W-1:0]    r_vec;
   logic [VEC_W-1:0]    w_vec_next;
   logic [VEC_W-1:0]    r_fail_idx;
   logic [VEC_W-1:0]    w_fail_idx_next;
   logic                r_fail;
   logic                w_fail_next;
   logic [SETTLE_W-1:0] r_settle;
   logic [SETTLE_W-1:0] w_settle_next;
   logic [SETTLE_W-1:0] r_cnt;
   logic [SETTLE_W-1:0] w_cnt_next;
   logic [7:0]          r_uo_out;
   logic [7:0]          r_uio_out;
   logic [7:0]          r_uio_oe;
   logic [7:0]          w_uo_next;
   logic [7:0]          w_uio_out_next;
   logic [7:0]          w_uio_oe_next;
   logic                w_start_edge;
   logic                w_launch;
   logic                w_mismatch;
   logic                w_busy_next;
   logic                w_done_next;
   logic                w_fail_show;
   logic                w_unused;

   assign w_start_edge = ui_in[UI_START] & ~r_start_d;
   assign w_unused     = ^{ui_in[3:2], uio_in[7], uio_in[3:0]};

   gate_exerciser_check u_check (
      .i_vec      (r_vec),
      .i_resp     (uio_in[UIO_RESP_LSB +: RESP_W]),
      .o_mismatch (w_mismatch)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else if (ena) begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_vec_next      = r_vec;
      w_fail_next     = r_fail;
      w_fail_idx_next = r_fail_idx;
      w_settle_next   = r_settle;
      w_cnt_next      = r_cnt;
      w_launch        = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_launch = w_start_edge;
         end
         S_DRIVE: begin
            w_cnt_next   = r_settle;
            w_state_next = (r_settle != '0) ? S_SETTLE : S_SAMPLE;
         end
         S_SETTLE: begin
            w_cnt_next = r_cnt - SETTLE_W'(1);
            if (r_cnt == SETTLE_W'(1)) begin
               w_state_next = S_SAMPLE;
            end
         end
         S_SAMPLE: begin
            // Only the first failing vector is kept.
            if (w_mismatch && !r_fail) begin
               w_fail_next     = 1'b1;
               w_fail_idx_next = r_vec;
            end
            if (r_vec == VEC_W'(VEC_COUNT - 1)) begin
               w_state_next = S_DONE;
            end else begin
               w_vec_next   = r_vec + VEC_W'(1);
               w_state_next = S_DRIVE;
            end
         end
         S_DONE: begin
            w_launch = w_start_edge | ui_in[UI_CONT];
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      if (w_launch) begin
         w_state_next    = S_DRIVE;
         w_vec_next      = '0;
         w_fail_next     = 1'b0;
         w_fail_idx_next = '0;
         w_settle_next   = ui_in[UI_SETTLE_LSB +: SETTLE_W];
      end
   end

   // Pin values are computed from next-state so every output is a flop.
   assign w_busy_next = (w_state_next == S_DRIVE) || (w_state_next == S_SETTLE) ||
                        (w_state_next == S_SAMPLE);
   assign w_done_next = (w_state_next == S_DONE);
   assign w_fail_show = w_done_next & w_fail_next;

   always_comb begin
      w_uo_next                        = '0;
      w_uo_next[UO_BUSY]               = w_busy_next;
      w_uo_next[UO_PASS]               = w_done_next & ~w_fail_next;
      w_uo_next[UO_FAIL]               = w_fail_show;
      w_uo_next[UO_DONE]               = w_done_next;
      w_uo_next[UO_IDX_LSB +: VEC_W]   = w_fail_show ? w_fail_idx_next : '0;
      w_uio_out_next                   = '0;
      w_uio_oe_next                    = '0;
      if (w_busy_next) begin
         w_uio_out_next[VEC_W-1:0] = w_vec_next;
         w_uio_oe_next             = OE_DRIVE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_start_d  <= 1'b0;
         r_vec      <= '0;
         r_fail     <= 1'b0;
         r_fail_idx <= '0;
         r_settle   <= '0;
         r_cnt      <= '0;
         r_uo_out   <= '0;
         r_uio_out  <= '0;
         r_uio_oe   <= '0;
      end else if (ena) begin
         r_start_d  <= ui_in[UI_START];
         r_vec      <= w_vec_next;
         r_fail     <= w_fail_next;
         r_fail_idx <= w_fail_idx_next;
         r_settle   <= w_settle_next;
         r_cnt      <= w_cnt_next;
         r_uo_out   <= w_uo_next;
         r_uio_out  <= w_uio_out_next;
         r_uio_oe   <= w_uio_oe_next;
      end
   end

   assign uo_out  = r_uo_out;
   assign uio_out = r_uio_out;
   assign uio_oe  = r_uio_oe;

endmodule
